// File: rtl/lpc_pkg.sv
// Shared LPC target definitions: FSM state encoding, CYCTYPE values,
// SYNC codes and the turn-around nibble.
package lpc_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CYC,
    ST_ADDR3,
    ST_ADDR2,
    ST_ADDR1,
    ST_ADDR0,
    ST_WDAT0,
    ST_WDAT1,
    ST_HTAR0,
    ST_HTAR1,
    ST_SYNC,
    ST_RDAT0,
    ST_RDAT1,
    ST_PTAR0,
    ST_PTAR1
  } lpc_state_e;

  localparam logic [3:0] LAD_START  = 4'b0000;
  localparam logic [3:0] CYC_IO_RD  = 4'b0000;
  localparam logic [3:0] CYC_IO_WR  = 4'b0010;
  localparam logic [3:0] SYNC_READY = 4'b0000;
  localparam logic [3:0] SYNC_LWAIT = 4'b0110;
  localparam logic [3:0] SYNC_ERR   = 4'b1010;
  localparam logic [3:0] LAD_TAR    = 4'b1111;

  localparam logic [15:0] POST_PORT = 16'h0080;

endpackage

// File: rtl/lpc_post_fifo.sv
// Port-80 POST code FIFO with a registered head and a sticky overflow flag.
module lpc_post_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  input  logic       i_ovf_clr,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0] ONE_CNT  = (PW+1)'(1);

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_count;
  logic [7:0]    r_head;
  logic          r_ovf;
  logic [PW-1:0] w_rptr_nxt;
  logic          w_full;
  logic          w_do_pop;
  logic          w_do_push;
  logic          w_ovf_evt;

  assign w_full     = (r_count == FULL_CNT);
  assign w_do_pop   = i_pop && (r_count != '0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_do_push  = i_push && (!w_full || w_do_pop);
  assign w_ovf_evt  = i_push && w_full && !w_do_pop;
  assign w_rptr_nxt = r_rptr + 1'b1;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_head  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= w_rptr_nxt;
      r_count <= r_count + {{PW{1'b0}}, w_do_push} - {{PW{1'b0}}, w_do_pop};
      if (w_do_pop) begin
        if (r_count > ONE_CNT) r_head <= r_mem[w_rptr_nxt];
        else if (w_do_push)    r_head <= i_data;
      end else if (w_do_push && (r_count == '0)) begin
        r_head <= i_data;
      end
      if (w_ovf_evt)      r_ovf <= 1'b1;
      else if (i_ovf_clr) r_ovf <= 1'b0;
    end
  end

  assign o_data  = r_head;
  assign o_valid = (r_count != '0);
  assign o_ovf   = r_ovf;

endmodule

// File: rtl/lpc_io_target.sv
// LPC IO-cycle target: register window with read/write strobes and long-wait
// SYNC, plus a port-80 POST code capture FIFO.
module lpc_io_target
  import lpc_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'h0800,
  parameter int          NUM_REGS   = 32,
  parameter int          POST_DEPTH = 8,
  parameter int          WAIT_MAX   = 15,
  localparam int         AW         = $clog2(NUM_REGS)
) (
  input  logic          LpcClock,
  input  logic          PciReset,
  input  logic          LpcFrame,
  input  logic [3:0]    LpcAdIn,
  output logic [3:0]    LpcAdOut,
  output logic          LpcAdOe,
  output logic          RegWr,
  output logic          RegRd,
  output logic [AW-1:0] RegAddr,
  output logic [7:0]    RegWrData,
  input  logic [7:0]    RegRdData,
  input  logic          RegReady,
  output logic [7:0]    PostData,
  output logic          PostValid,
  input  logic          PostPop,
  output logic          PostOvf,
  input  logic          PostOvfClr
);

  localparam logic [16:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [16:0] WIN_HI = WIN_LO + 17'(NUM_REGS) - 17'd1;

  lpc_state_e    r_state;
  logic          r_is_wr;
  logic          r_p80;
  logic [11:0]   r_addr_hi;
  logic [3:0]    r_wd_lo;
  logic [3:0]    r_rd_hi;
  logic [7:0]    r_wait_cnt;
  logic          r_sync_done;
  logic          r_sync_err;
  logic [3:0]    r_lad_out;
  logic          r_oe;
  logic          r_reg_wr;
  logic          r_reg_rd;
  logic          r_push;
  logic [AW-1:0] r_reg_addr;
  logic [7:0]    r_reg_wr_data;

  logic [15:0]   w_addr;
  logic [AW-1:0] w_offset;
  logic          w_win_hit;
  logic          w_p80_hit;

  assign w_addr    = {r_addr_hi, LpcAdIn};
  assign w_offset  = AW'(w_addr - BASE_ADDR);
  assign w_win_hit = ({1'b0, w_addr} >= WIN_LO) && ({1'b0, w_addr} <= WIN_HI);
  assign w_p80_hit = r_is_wr && (w_addr == POST_PORT);

  // Outputs are registered: each branch sets the values for the state it enters.
  always_ff @(posedge LpcClock or posedge PciReset) begin
    if (PciReset) begin
      r_state       <= ST_IDLE;
      r_is_wr       <= 1'b0;
      r_p80         <= 1'b0;
      r_addr_hi     <= '0;
      r_wd_lo       <= '0;
      r_rd_hi       <= '0;
      r_wait_cnt    <= '0;
      r_sync_done   <= 1'b0;
      r_sync_err    <= 1'b0;
      r_lad_out     <= LAD_TAR;
      r_oe          <= 1'b0;
      r_reg_wr      <= 1'b0;
      r_reg_rd      <= 1'b0;
      r_push        <= 1'b0;
      r_reg_addr    <= '0;
      r_reg_wr_data <= '0;
    end else begin
      r_reg_wr  <= 1'b0;
      r_reg_rd  <= 1'b0;
      r_push    <= 1'b0;
      r_oe      <= 1'b0;
      r_lad_out <= LAD_TAR;
      if (!LpcFrame && (r_state != ST_IDLE) && (r_state != ST_CYC)) begin
        r_state    <= (LpcAdIn == LAD_START) ? ST_CYC : ST_IDLE;
        r_wait_cnt <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_wait_cnt <= '0;
            if (!LpcFrame && (LpcAdIn == LAD_START)) r_state <= ST_CYC;
          end
          ST_CYC: begin
            if (!LpcFrame) begin
              if (LpcAdIn != LAD_START) r_state <= ST_IDLE;
            end else if ((LpcAdIn == CYC_IO_RD) || (LpcAdIn == CYC_IO_WR)) begin
              r_is_wr <= (LpcAdIn == CYC_IO_WR);
              r_state <= ST_ADDR3;
            end else begin
              r_state <= ST_IDLE;
            end
          end
          ST_ADDR3: begin r_addr_hi[11:8] <= LpcAdIn; r_state <= ST_ADDR2; end
          ST_ADDR2: begin r_addr_hi[7:4]  <= LpcAdIn; r_state <= ST_ADDR1; end
          ST_ADDR1: begin r_addr_hi[3:0]  <= LpcAdIn; r_state <= ST_ADDR0; end
          ST_ADDR0: begin
            if (w_p80_hit) begin
              r_p80   <= 1'b1;
              r_state <= ST_WDAT0;
            end else if (w_win_hit) begin
              r_p80      <= 1'b0;
              r_reg_addr <= w_offset;
              r_state    <= r_is_wr ? ST_WDAT0 : ST_HTAR0;
            end else begin
              r_state <= ST_IDLE;
            end
          end
          ST_WDAT0: begin r_wd_lo <= LpcAdIn; r_state <= ST_WDAT1; end
          ST_WDAT1: begin r_reg_wr_data <= {LpcAdIn, r_wd_lo}; r_state <= ST_HTAR0; end
          ST_HTAR0: begin
            r_state <= ST_HTAR1;
            if (r_p80)        r_push   <= 1'b1;
            else if (r_is_wr) r_reg_wr <= 1'b1;
            else              r_reg_rd <= 1'b1;
          end
          ST_HTAR1: begin
            r_state    <= ST_SYNC;
            r_oe       <= 1'b1;
            r_sync_err <= 1'b0;
            if (RegReady || r_p80) begin
              r_lad_out   <= SYNC_READY;
              r_sync_done <= 1'b1;
            end else begin
              r_lad_out   <= SYNC_LWAIT;
              r_sync_done <= 1'b0;
              r_wait_cnt  <= 8'd1;
            end
          end
          ST_SYNC: begin
            r_oe <= 1'b1;
            if (r_sync_done) begin
              r_wait_cnt <= '0;
              if (!r_sync_err && !r_is_wr) begin
                r_lad_out <= RegRdData[3:0];
                r_rd_hi   <= RegRdData[7:4];
                r_state   <= ST_RDAT0;
              end else begin
                r_state <= ST_PTAR0;
              end
            end else if (RegReady) begin
              r_lad_out   <= SYNC_READY;
              r_sync_done <= 1'b1;
            end else if (r_wait_cnt == 8'(WAIT_MAX)) begin
              r_lad_out   <= SYNC_ERR;
              r_sync_done <= 1'b1;
              r_sync_err  <= 1'b1;
            end else begin
              r_lad_out  <= SYNC_LWAIT;
              r_wait_cnt <= r_wait_cnt + 8'd1;
            end
          end
          ST_RDAT0: begin r_oe <= 1'b1; r_lad_out <= r_rd_hi; r_state <= ST_RDAT1; end
          ST_RDAT1: begin r_oe <= 1'b1; r_state <= ST_PTAR0; end
          ST_PTAR0: r_state <= ST_PTAR1;
          ST_PTAR1: r_state <= ST_IDLE;
          default:  r_state <= ST_IDLE;
        endcase
      end
    end
  end

  lpc_post_fifo #(
    .DEPTH(POST_DEPTH)
  ) u_post_fifo (
    .clk       (LpcClock),
    .rst       (PciReset),
    .i_push    (r_push),
    .i_data    (r_reg_wr_data),
    .i_pop     (PostPop),
    .i_ovf_clr (PostOvfClr),
    .o_data    (PostData),
    .o_valid   (PostValid),
    .o_ovf     (PostOvf)
  );

  assign LpcAdOut  = r_lad_out;
  assign LpcAdOe   = r_oe;
  assign RegWr     = r_reg_wr;
  assign RegRd     = r_reg_rd;
  assign RegAddr   = r_reg_addr;
  assign RegWrData = r_reg_wr_data;

endmodule

// File: tb/tb_lpc_io_target.sv
// Directed bench for lpc_io_target: window reads/writes, long-wait and error
// SYNC, address miss, abort, port-80 FIFO overflow and mid-cycle reset.
module tb_lpc_io_target;
  import lpc_pkg::*;

  logic       LpcClock;
  logic       PciReset;
  logic       LpcFrame;
  logic [3:0] LpcAdIn;
  logic [3:0] LpcAdOut;
  logic       LpcAdOe;
  logic       RegWr;
  logic       RegRd;
  logic [4:0] RegAddr;
  logic [7:0] RegWrData;
  logic [7:0] RegRdData;
  logic       RegReady;
  logic [7:0] PostData;
  logic       PostValid;
  logic       PostPop;
  logic       PostOvf;
  logic       PostOvfClr;

  int n_cmp = 0;
  int n_err = 0;
  int oe_cnt = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int snap_oe, snap_wr, snap_rd;

  logic [3:0] r_nibs [32];
  int         r_n;
  logic [3:0] exp_q [$];

  lpc_io_target dut (
    .LpcClock   (LpcClock),
    .PciReset   (PciReset),
    .LpcFrame   (LpcFrame),
    .LpcAdIn    (LpcAdIn),
    .LpcAdOut   (LpcAdOut),
    .LpcAdOe    (LpcAdOe),
    .RegWr      (RegWr),
    .RegRd      (RegRd),
    .RegAddr    (RegAddr),
    .RegWrData  (RegWrData),
    .RegRdData  (RegRdData),
    .RegReady   (RegReady),
    .PostData   (PostData),
    .PostValid  (PostValid),
    .PostPop    (PostPop),
    .PostOvf    (PostOvf),
    .PostOvfClr (PostOvfClr)
  );

  // clock / activity monitors
  initial LpcClock = 1'b0;
  always #15 LpcClock = ~LpcClock;

  always @(negedge LpcClock) begin
    if (LpcAdOe === 1'b1) oe_cnt++;
    if (RegWr === 1'b1)   wr_cnt++;
    if (RegRd === 1'b1)   rd_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge LpcClock);
  endtask

  // Host side of one IO cycle; returns while the HTAR1 nibble is on the bus.
  task automatic host_cycle(input logic is_wr, input logic [15:0] addr,
                            input logic [7:0] data, input int abort_slot);
    logic [3:0] nib [10];
    int         n;
    logic       aborted;
    nib[0] = LAD_START;
    nib[1] = is_wr ? CYC_IO_WR : CYC_IO_RD;
    nib[2] = addr[15:12];
    nib[3] = addr[11:8];
    nib[4] = addr[7:4];
    nib[5] = addr[3:0];
    nib[6] = is_wr ? data[3:0] : LAD_TAR;
    nib[7] = is_wr ? data[7:4] : LAD_TAR;
    nib[8] = LAD_TAR;
    nib[9] = LAD_TAR;
    n = is_wr ? 10 : 8;
    aborted = 1'b0;
    for (int k = 0; k < n && !aborted; k++) begin
      @(posedge LpcClock); #1;
      if (k == abort_slot) begin
        LpcFrame = 1'b0;
        LpcAdIn  = LAD_TAR;
        aborted  = 1'b1;
        @(posedge LpcClock); #1;
        LpcFrame = 1'b1;
      end else begin
        LpcFrame = (k == 0) ? 1'b0 : 1'b1;
        LpcAdIn  = nib[k];
      end
    end
  endtask

  // Records every driven nibble until the target releases LAD.
  task automatic collect(input int ready_after);
    int   waits;
    logic seen;
    logic done;
    waits = 0; seen = 1'b0; done = 1'b0; r_n = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge LpcClock);
      if (LpcAdOe === 1'b1) begin
        seen = 1'b1;
        if (r_n < 32) begin
          r_nibs[r_n] = LpcAdOut;
          r_n++;
        end
        if (LpcAdOut === SYNC_LWAIT) begin
          waits++;
          if (waits == ready_after) RegReady = 1'b1;
        end
      end else if (seen) begin
        done = 1'b1;
      end
    end
    check("resp_release", 32'(done), 32'd1);
  endtask

  task automatic check_resp(input string tag);
    check({tag, "_len"}, 32'(r_n), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < r_n) check($sformatf("%s_nib%0d", tag, i), 32'(r_nibs[i]), 32'(exp_q[i]));
    end
    exp_q.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_oe"},    32'(LpcAdOe),   32'd0);
    check({tag, "_lad"},   32'(LpcAdOut),  32'hF);
    check({tag, "_wr"},    32'(RegWr),     32'd0);
    check({tag, "_rd"},    32'(RegRd),     32'd0);
    check({tag, "_addr"},  32'(RegAddr),   32'd0);
    check({tag, "_wdat"},  32'(RegWrData), 32'd0);
    check({tag, "_pval"},  32'(PostValid), 32'd0);
    check({tag, "_pdata"}, 32'(PostData),  32'd0);
    check({tag, "_povf"},  32'(PostOvf),   32'd0);
  endtask

  initial begin
    PciReset = 1'b1; LpcFrame = 1'b1; LpcAdIn = LAD_TAR;
    RegRdData = 8'h00; RegReady = 1'b1; PostPop = 1'b0; PostOvfClr = 1'b0;
    idle(3);
    @(negedge LpcClock);
    check_reset_values("rst");
    @(posedge LpcClock); #1 PciReset = 1'b0;
    idle(2);

    // write 0x0805 <= 0xA5, ready immediately
    snap_wr = wr_cnt;
    host_cycle(1'b1, 16'h0805, 8'hA5, -1);
    @(negedge LpcClock);
    check("wr_strobe", 32'(RegWr), 32'd1);
    check("wr_addr",   32'(RegAddr), 32'd5);
    check("wr_data",   32'(RegWrData), 32'hA5);
    exp_q.push_back(SYNC_READY); exp_q.push_back(LAD_TAR);
    collect(0);
    check_resp("wr0805");
    check("wr_pulses", 32'(wr_cnt - snap_wr), 32'd1);

    // read 0x0803 = 0x3C with three long-wait cycles
    RegReady = 1'b0; RegRdData = 8'h3C; snap_rd = rd_cnt;
    host_cycle(1'b0, 16'h0803, 8'h00, -1);
    @(negedge LpcClock);
    check("rd_strobe", 32'(RegRd), 32'd1);
    check("rd_addr",   32'(RegAddr), 32'd3);
    repeat (3) exp_q.push_back(SYNC_LWAIT);
    exp_q.push_back(SYNC_READY); exp_q.push_back(4'hC); exp_q.push_back(4'h3);
    exp_q.push_back(LAD_TAR);
    collect(3);
    check_resp("rd0803");
    check("rd_pulses", 32'(rd_cnt - snap_rd), 32'd1);

    // read 0x0801 never ready: 15 waits then error SYNC, no data phase
    RegReady = 1'b0;
    host_cycle(1'b0, 16'h0801, 8'h00, -1);
    @(negedge LpcClock);
    check("rdto_addr", 32'(RegAddr), 32'd1);
    repeat (15) exp_q.push_back(SYNC_LWAIT);
    exp_q.push_back(SYNC_ERR); exp_q.push_back(LAD_TAR);
    collect(0);
    check_resp("rd0801_to");
    RegReady = 1'b1;

    // out-of-window write 0x0900
    snap_oe = oe_cnt; snap_wr = wr_cnt;
    host_cycle(1'b1, 16'h0900, 8'h11, -1);
    idle(4);
    check("miss_oe", 32'(oe_cnt - snap_oe), 32'd0);
    check("miss_wr", 32'(wr_cnt - snap_wr), 32'd0);

    // abort during WDAT1 of a 0x0802 write
    snap_oe = oe_cnt; snap_wr = wr_cnt;
    host_cycle(1'b1, 16'h0802, 8'hC3, 7);
    idle(4);
    check("abort_oe", 32'(oe_cnt - snap_oe), 32'd0);
    check("abort_wr", 32'(wr_cnt - snap_wr), 32'd0);

    // target recovers after the abort
    host_cycle(1'b1, 16'h0802, 8'h5A, -1);
    @(negedge LpcClock);
    check("rec_strobe", 32'(RegWr), 32'd1);
    check("rec_addr",   32'(RegAddr), 32'd2);
    check("rec_data",   32'(RegWrData), 32'h5A);
    exp_q.push_back(SYNC_READY); exp_q.push_back(LAD_TAR);
    collect(0);
    check_resp("rec0802");

    // nine port-80 writes into an 8-deep FIFO; first one with RegReady low
    snap_wr = wr_cnt;
    for (int i = 1; i <= 9; i++) begin
      RegReady = (i == 1) ? 1'b0 : 1'b1;
      host_cycle(1'b1, 16'h0080, 8'(i), -1);
      exp_q.push_back(SYNC_READY); exp_q.push_back(LAD_TAR);
      collect(0);
      check_resp($sformatf("p80_%0d", i));
    end
    RegReady = 1'b1;
    @(negedge LpcClock);
    check("p80_valid", 32'(PostValid), 32'd1);
    check("p80_head",  32'(PostData), 32'd1);
    check("p80_ovf",   32'(PostOvf), 32'd1);
    check("p80_no_wr", 32'(wr_cnt - snap_wr), 32'd0);
    @(posedge LpcClock); #1 PostOvfClr = 1'b1;
    @(posedge LpcClock); #1 PostOvfClr = 1'b0;
    @(negedge LpcClock);
    check("p80_ovf_clr", 32'(PostOvf), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge LpcClock);
      check($sformatf("pop%0d_valid", i), 32'(PostValid), 32'd1);
      check($sformatf("pop%0d_data", i),  32'(PostData), 32'(i));
      @(posedge LpcClock); #1 PostPop = 1'b1;
      @(posedge LpcClock); #1 PostPop = 1'b0;
    end
    @(negedge LpcClock);
    check("p80_drained", 32'(PostValid), 32'd0);
    @(posedge LpcClock); #1 PostPop = 1'b1;
    @(posedge LpcClock); #1 PostPop = 1'b0;
    @(negedge LpcClock);
    check("empty_pop_valid", 32'(PostValid), 32'd0);
    check("empty_pop_ovf",   32'(PostOvf), 32'd0);

    // reset pulse while RDAT0 is on the bus
    host_cycle(1'b1, 16'h0080, 8'h42, -1);
    exp_q.push_back(SYNC_READY); exp_q.push_back(LAD_TAR);
    collect(0);
    check_resp("p80_pre");
    @(negedge LpcClock);
    check("pre_rst_valid", 32'(PostValid), 32'd1);
    check("pre_rst_data",  32'(PostData), 32'h42);
    RegRdData = 8'h77;
    host_cycle(1'b0, 16'h0804, 8'h00, -1);
    @(posedge LpcClock);
    @(posedge LpcClock);
    #2;
    check("rdat0_oe",  32'(LpcAdOe), 32'd1);
    check("rdat0_lad", 32'(LpcAdOut), 32'h7);
    #3 PciReset = 1'b1;
    #1;
    check_reset_values("midrst");
    snap_rd = rd_cnt; snap_oe = oe_cnt;
    @(posedge LpcClock); #1 PciReset = 1'b0;
    idle(6);
    @(negedge LpcClock);
    check("postrst_rd", 32'(rd_cnt - snap_rd), 32'd0);
    check("postrst_oe", 32'(oe_cnt - snap_oe), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lpc_io_target.md
LPC_IO_TARGET -- requirements
Module: lpc_io_target

Interface
REQ-001 Parameters (name, default, meaning):
- BASE_ADDR, 16'h0800, first IO address of the register window.
- NUM_REGS, 32, register count (2..256); AW = clog2(NUM_REGS).
- POST_DEPTH, 8, port-80 FIFO depth (power of 2, >= 2).
- WAIT_MAX, 15, maximum long-wait SYNC cycles before error SYNC (1..255).
REQ-002 Ports (name, direction, width, meaning):
- LpcClock, in, 1, 33 MHz LPC clock; the only clock.
- PciReset, in, 1, asynchronous, active-high reset.
- LpcFrame, in, 1, LFRAME#, active low.
- LpcAdIn, in, 4, LAD sampled value.
- LpcAdOut, out, 4, LAD drive value.
- LpcAdOe, out, 1, LAD output enable.
- RegWr, out, 1, one-cycle register write strobe.
- RegRd, out, 1, one-cycle register read strobe.
- RegAddr, out, AW, register offset (IO address - BASE_ADDR).
- RegWrData, out, 8, register write data.
- RegRdData, in, 8, register read data.
- RegReady, in, 1, register side ready; low requests long-wait.
- PostData, out, 8, FIFO head (port-80 code).
- PostValid, out, 1, FIFO non-empty.
- PostPop, in, 1, dequeue head.
- PostOvf, out, 1, sticky overflow flag.
- PostOvfClr, in, 1, clears PostOvf.

Function
REQ-003 START: LpcFrame=0 and LpcAdIn=4'b0000 in IDLE; CYCTYPE sampled on the first cycle with LpcFrame=1. 4'b0000 = IO read, 4'b0010 = IO write; any other value returns to IDLE and drives nothing.
REQ-004 FSM states: IDLE, CYC, ADDR3..ADDR0 (MSB nibble first), WDAT0/WDAT1 (low nibble first, write only), HTAR0, HTAR1, SYNC, RDAT0/RDAT1 (read only), PTAR0, PTAR1.
REQ-005 Decode after ADDR0: hit when BASE_ADDR <= addr <= BASE_ADDR+NUM_REGS-1, or addr == 16'h0080 and cycle is a write. A miss returns to IDLE and never asserts LpcAdOe, RegWr or RegRd.
REQ-006 Window hit: RegWr or RegRd pulses for exactly one cycle in HTAR1, with RegAddr and RegWrData stable from HTAR1 until return to IDLE.
REQ-007 Port-80 hit: the data byte is pushed into the FIFO in HTAR1, with no RegWr; SYNC is always ready.
REQ-008 SYNC: LpcAdOe=1. Drive 4'b0000 when RegReady=1. Otherwise drive 4'b0110 each cycle and count; after WAIT_MAX consecutive wait cycles, drive 4'b1010 (error), skip RDAT, and go to PTAR0.
REQ-009 Read data: RDAT0 drives RegRdData[3:0] and RDAT1 drives RegRdData[7:4]; RegRdData is sampled in the ready-SYNC cycle.
REQ-010 PTAR0 drives 4'b1111 with LpcAdOe=1; PTAR1 sets LpcAdOe=0; then IDLE.
REQ-011 LpcAdOe=0 in every state except SYNC, RDAT0, RDAT1 and PTAR0.
REQ-012 Abort: LpcFrame=0 in any state other than IDLE/CYC:
- LpcAdOe drops next cycle and the FSM re-enters START evaluation.
- Strobes or pushes not yet issued are suppressed.
REQ-013 FIFO push when full: the byte is dropped and PostOvf is set. A simultaneous pop and push when full is accepted with no overflow. A pop when empty is ignored.
REQ-014 PostOvfClr clears PostOvf; a simultaneous overflow event wins (PostOvf stays 1).
REQ-015 FIFO pointers wrap modulo POST_DEPTH; PostData is the registered head and valid whenever PostValid=1.

Reset
REQ-016 While PciReset=1: FSM=IDLE, LpcAdOe=0, LpcAdOut=4'b1111, RegWr=RegRd=0, RegAddr=0, RegWrData=0, FIFO empty, PostValid=0, PostData=0, PostOvf=0, wait counter=0.
REQ-017 Reset mid-cycle releases LAD immediately (asynchronously); the interrupted cycle issues no strobe after reset deasserts.

Structure
REQ-018 Package lpc_pkg holds the state enum, the CYCTYPE constants, the SYNC codes (READY 4'b0000, LWAIT 4'b0110, ERR 4'b1010) and the TAR value 4'b1111.
REQ-019 One sub-module, lpc_post_fifo (parametrised by POST_DEPTH, with overflow logic), instantiated once.

Verification
REQ-020 IO write 0x0805 data 0xA5, RegReady=1 -> RegWr pulse in HTAR1, RegAddr=5, RegWrData=0xA5, SYNC 0000, LAD released after PTAR1.
REQ-021 IO read 0x0803, RegRdData=0x3C, RegReady low 3 cycles -> SYNC 0110 x3 then 0000, RDAT0=C, RDAT1=3.
REQ-022 IO read 0x0801, RegReady held low, WAIT_MAX=15 -> 15 cycles of 0110, then 1010, no RDAT phase.
REQ-023 Write 0x0080 x9 with data 1..9, POST_DEPTH=8, no pops -> PostValid=1, PostData=1, PostOvf=1, byte 9 lost; PostOvfClr -> PostOvf=0.
REQ-024 IO write 0x0900 (out of window) -> LpcAdOe never 1, no RegWr; abort (LpcFrame=0) in WDAT1 of a 0x0802 write -> no RegWr.
REQ-025 PciReset pulse during RDAT0 -> LpcAdOe=0 within the same cycle; all outputs at REQ-016 values.
